ex_mem_stage: RTL and testbench
===============================

// Module: ex_mem_stage
// PURPOSE
//  EX->MEM pipeline stage placed directly downstream of the 64-bit ALU.
//  - Captures ALU result/zero, store data, destination register and memory/writeback controls.
//  - Resolves CBZ/B branch outcomes from the ALU zero flag.
//  - Decouples EX from MEM through a valid/ready handshake backed by a 2-entry skid buffer
//    (output register + skid register), so MEM back-pressure never drops an operation.
// PARAMETERS
//  DATA_W  64  width of ALU result, store data, branch target
//  REG_AW  5   width of destination register index
// PORTS
//  clk             in   1       clock, all state updates on rising edge
//  rst_n           in   1       asynchronous, active-low reset
//  flush_i         in   1       discard all held entries (exception/redirect)
//  ex_valid_i      in   1       EX presents an operation
//  ex_ready_o      out  1       stage can accept; handshake = ex_valid_i & ex_ready_o
//  ex_alu_result_i in   DATA_W  ALU output
//  ex_zero_i       in   1       ALU zero flag
//  ex_store_data_i in   DATA_W  register data for STUR
//  ex_rd_i         in   REG_AW  destination register
//  ex_ctrl_i       in   5       {reg_write, mem_to_reg, mem_read, mem_write, branch}
//  ex_uncond_i     in   1       unconditional branch (B)
//  ex_br_target_i  in   DATA_W  computed branch target
//  mem_valid_o     out  1       output register holds an operation
//  mem_ready_i     in   1       MEM consumes; handshake = mem_valid_o & mem_ready_i
//  mem_alu_result_o out DATA_W  address / result to MEM
//  mem_store_data_o out DATA_W  store data
//  mem_rd_o        out  REG_AW  destination register
//  mem_ctrl_o      out  4       {reg_write, mem_to_reg, mem_read, mem_write}
//  br_taken_o      out  1       one-cycle pulse: taken branch accepted last cycle
//  br_target_o     out  DATA_W  target valid while br_taken_o=1
//  perf_stall_o    out  32      cycles with mem_valid_o & ~mem_ready_i
//  perf_br_o       out  32      count of taken branches
// BEHAVIOUR
//  - Reset: both entries invalid.
//    - Outputs: ex_ready_o=1, mem_valid_o=0, br_taken_o=0, perf_* = 0; all data outputs = 0.
//  - ex_ready_o is registered: ex_ready_o = ~skid_valid.
//  - Accept cycle (ex handshake, no flush):
//    - If output register is empty or mem_ready_i=1 and skid is empty: write into output register;
//      mem_valid_o=1 next cycle (latency 1).
//    - Otherwise (output occupied and stalled): write into skid; ex_ready_o=0 next cycle.
//  - On MEM handshake with skid valid:
//    - Skid entry moves to the output register; skid clears; ex_ready_o=1 next cycle.
//    - A same-cycle ex handshake is impossible here, since ex_ready_o=0 while skid is valid.
//  - Order preserved: FIFO; the skid entry always precedes any newer entry.
//  - Full (both valid): ex_ready_o=0; the held entries are unchanged until mem_ready_i.
//  - Branch resolution on accept: taken = ex_uncond_i | (ex_ctrl_i[0] & ex_zero_i).
//    - br_taken_o=1 and br_target_o=ex_br_target_i on the next cycle only, independent of MEM stall.
//    - Branch ops still enter the pipe (mem_ctrl_o as given) so MEM sees them.
//  - flush_i=1: both entries invalid next cycle; mem_valid_o=0, ex_ready_o=1.
//    - An ex handshake in the same cycle is dropped: no entry, no br_taken_o.
//    - Flush also suppresses a br_taken_o pulse due in the following cycle.
//  - Data outputs hold their last value when mem_valid_o=0; consumers must qualify with valid.
//  - Reset asserted mid-operation clears everything asynchronously.
//    - First accept is possible in the first cycle after rst_n rises.
//  - Counters are 32-bit, wrap from 0xFFFFFFFF to 0 with no saturation.
// CONFIGURATION
//  EXMEM_PERF_CNT_EN
//    - Defined: perf_stall_o and perf_br_o count as above; cleared by reset, not by flush.
//    - Undefined: the counter registers are not built; perf_stall_o = perf_br_o = 32'd0 constant.
//    - All ports exist in both builds.
// TESTING
//  1. Streaming, mem_ready_i=1: accept ALU results 5, 6, 7 back-to-back.
//     -> mem_valid_o high cycles 1-3 with 5, 6, 7; ex_ready_o stays 1.
//  2. Back-pressure: hold A=0x10; mem_ready_i=0; offer B=0x20, then C=0x30.
//     -> B goes to skid, ex_ready_o=0, C held off.
//     -> Raise mem_ready_i: outputs A, then B, then C, in order, none lost.
//  3. CBZ with ex_zero_i=1, branch=1, target 0x400.
//     -> Next cycle br_taken_o=1, br_target_o=0x400, for exactly one cycle.
//     -> Repeat with ex_zero_i=0: br_taken_o stays 0.
//  4. Flush with both entries full and a simultaneous ex handshake.
//     -> Next cycle mem_valid_o=0, ex_ready_o=1; the dropped op never appears; no br_taken_o.
//  5. Reset mid-stall: rst_n=0 with both entries valid.
//     -> Immediately mem_valid_o=0, ex_ready_o=1, br_taken_o=0.
//     -> After release, the first accepted op appears after 1 cycle.
//  6. With EXMEM_PERF_CNT_EN: stall 7 cycles and take 3 branches.
//     -> perf_stall_o=7, perf_br_o=3.
//     -> Without the macro: both remain 0.

Source files
------------

// File: rtl/ex_mem_stage_if.sv
// EX/MEM stage bus: EX-side offer, MEM-side output, branch resolution and perf counters.
// slave is the stage's view; master is the surrounding pipeline's view.
interface ex_mem_stage_if #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned REG_AW = 5
);
  logic              flush_i;
  logic              ex_valid_i;
  logic              ex_ready_o;
  logic [DATA_W-1:0] ex_alu_result_i;
  logic              ex_zero_i;
  logic [DATA_W-1:0] ex_store_data_i;
  logic [REG_AW-1:0] ex_rd_i;
  logic [4:0]        ex_ctrl_i;
  logic              ex_uncond_i;
  logic [DATA_W-1:0] ex_br_target_i;
  logic              mem_valid_o;
  logic              mem_ready_i;
  logic [DATA_W-1:0] mem_alu_result_o;
  logic [DATA_W-1:0] mem_store_data_o;
  logic [REG_AW-1:0] mem_rd_o;
  logic [3:0]        mem_ctrl_o;
  logic              br_taken_o;
  logic [DATA_W-1:0] br_target_o;
  logic [31:0]       perf_stall_o;
  logic [31:0]       perf_br_o;

  modport slave (
    input  flush_i, ex_valid_i, ex_alu_result_i, ex_zero_i, ex_store_data_i, ex_rd_i,
           ex_ctrl_i, ex_uncond_i, ex_br_target_i, mem_ready_i,
    output ex_ready_o, mem_valid_o, mem_alu_result_o, mem_store_data_o, mem_rd_o, mem_ctrl_o,
           br_taken_o, br_target_o, perf_stall_o, perf_br_o
  );

  modport master (
    output flush_i, ex_valid_i, ex_alu_result_i, ex_zero_i, ex_store_data_i, ex_rd_i,
           ex_ctrl_i, ex_uncond_i, ex_br_target_i, mem_ready_i,
    input  ex_ready_o, mem_valid_o, mem_alu_result_o, mem_store_data_o, mem_rd_o, mem_ctrl_o,
           br_taken_o, br_target_o, perf_stall_o, perf_br_o
  );
endinterface

// File: rtl/ex_mem_stage.sv
// EX->MEM pipeline stage: output register + skid register, CBZ/B resolution from ALU zero.
// Define EXMEM_PERF_CNT_EN to build the stall and taken-branch counters.
module ex_mem_stage #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned REG_AW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  ex_mem_stage_if.slave bus
);

  typedef struct packed {
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] store_data;
    logic [REG_AW-1:0] rd;
    logic [3:0]        ctrl;
  } entry_t;

  entry_t            r_out;
  entry_t            r_skid;
  entry_t            w_new;
  logic              r_out_valid;
  logic              r_skid_valid;
  logic              r_br_taken;
  logic [DATA_W-1:0] r_br_target;
  logic              w_accept;
  logic              w_mem_hs;
  logic              w_taken;

  assign w_new.alu_result = bus.ex_alu_result_i;
  assign w_new.store_data = bus.ex_store_data_i;
  assign w_new.rd         = bus.ex_rd_i;
  assign w_new.ctrl       = bus.ex_ctrl_i[4:1];

  // A flushed offer is never accepted, so it can neither enter the pipe nor raise a branch.
  assign w_accept = bus.ex_valid_i & ~r_skid_valid & ~bus.flush_i;
  assign w_mem_hs = r_out_valid & bus.mem_ready_i;
  assign w_taken  = bus.ex_uncond_i | (bus.ex_ctrl_i[0] & bus.ex_zero_i);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out        <= '0;
      r_skid       <= '0;
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (bus.flush_i) begin
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (r_skid_valid) begin
      // ex_ready_o is low here, so only the drain of the skid entry can happen.
      if (w_mem_hs) begin
        r_out        <= r_skid;
        r_skid_valid <= 1'b0;
      end
    end else if (w_accept) begin
      if (!r_out_valid || bus.mem_ready_i) begin
        r_out       <= w_new;
        r_out_valid <= 1'b1;
      end else begin
        r_skid       <= w_new;
        r_skid_valid <= 1'b1;
      end
    end else if (w_mem_hs) begin
      r_out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_br_taken  <= 1'b0;
      r_br_target <= '0;
    end else begin
      r_br_taken <= w_accept & w_taken;
      if (w_accept && w_taken) begin
        r_br_target <= bus.ex_br_target_i;
      end
    end
  end

  assign bus.ex_ready_o       = ~r_skid_valid;
  assign bus.mem_valid_o      = r_out_valid;
  assign bus.mem_alu_result_o = r_out.alu_result;
  assign bus.mem_store_data_o = r_out.store_data;
  assign bus.mem_rd_o         = r_out.rd;
  assign bus.mem_ctrl_o       = r_out.ctrl;
  assign bus.br_taken_o       = r_br_taken;
  assign bus.br_target_o      = r_br_target;

`ifdef EXMEM_PERF_CNT_EN
  logic [31:0] r_perf_stall;
  logic [31:0] r_perf_br;

  // Free-running, wrap at 2^32; flush leaves them alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_stall <= 32'd0;
      r_perf_br    <= 32'd0;
    end else begin
      if (r_out_valid && !bus.mem_ready_i) begin
        r_perf_stall <= r_perf_stall + 32'd1;
      end
      if (w_accept && w_taken) begin
        r_perf_br <= r_perf_br + 32'd1;
      end
    end
  end

  assign bus.perf_stall_o = r_perf_stall;
  assign bus.perf_br_o    = r_perf_br;
`else
  assign bus.perf_stall_o = 32'd0;
  assign bus.perf_br_o    = 32'd0;
`endif

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed bench for ex_mem_stage: vector table for streaming/back-pressure/branches,
// hand sequences for flush, asynchronous reset and the perf counters.
module tb_ex_mem_stage;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  ex_mem_stage_if #(.DATA_W(64), .REG_AW(5)) u_if ();

  ex_mem_stage #(.DATA_W(64), .REG_AW(5)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if)
  );

  typedef struct {
    logic        v;
    logic [63:0] alu;
    logic [4:0]  ctrl;
    logic        zero;
    logic        unc;
    logic [63:0] tgt;
    logic        mrdy;
    logic        e_rdy;
    logic        e_mval;
    logic [63:0] e_alu;
    logic [3:0]  e_ctrl;
    logic        e_brt;
    logic [63:0] e_tgt;
  } vec_t;

  vec_t tbl[18];

  function automatic vec_t mk(input logic v, input logic [63:0] alu, input logic [4:0] ctrl,
                              input logic zero, input logic unc, input logic [63:0] tgt,
                              input logic mrdy, input logic e_rdy, input logic e_mval,
                              input logic [63:0] e_alu, input logic [3:0] e_ctrl,
                              input logic e_brt, input logic [63:0] e_tgt);
    vec_t r;
    r.v = v; r.alu = alu; r.ctrl = ctrl; r.zero = zero; r.unc = unc; r.tgt = tgt;
    r.mrdy = mrdy; r.e_rdy = e_rdy; r.e_mval = e_mval; r.e_alu = e_alu; r.e_ctrl = e_ctrl;
    r.e_brt = e_brt; r.e_tgt = e_tgt;
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Store data and rd are derived from the ALU value so one table column checks all three.
  task automatic drive(input logic v, input logic [63:0] alu, input logic [4:0] ctrl,
                       input logic zero, input logic unc, input logic [63:0] tgt,
                       input logic mrdy, input logic fl);
    u_if.ex_valid_i      = v;
    u_if.ex_alu_result_i = alu;
    u_if.ex_store_data_i = alu + 64'h1000;
    u_if.ex_rd_i         = alu[4:0];
    u_if.ex_ctrl_i       = ctrl;
    u_if.ex_zero_i       = zero;
    u_if.ex_uncond_i     = unc;
    u_if.ex_br_target_i  = tgt;
    u_if.mem_ready_i     = mrdy;
    u_if.flush_i         = fl;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_data(input string tag, input logic [63:0] e_alu);
    logic [63:0] e = e_alu;
    chk({tag, " alu"}, u_if.mem_alu_result_o, e);
    chk({tag, " store"}, u_if.mem_store_data_o, e + 64'h1000);
    chk({tag, " rd"}, {59'd0, u_if.mem_rd_o}, {59'd0, e[4:0]});
  endtask

  localparam logic [31:0] EXP_STALL =
`ifdef EXMEM_PERF_CNT_EN
    32'd7;
`else
    32'd0;
`endif
  localparam logic [31:0] EXP_BR =
`ifdef EXMEM_PERF_CNT_EN
    32'd3;
`else
    32'd0;
`endif

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    //            v  alu    ctrl      z  u  tgt     mrdy rdy mval e_alu  e_ctrl   brt e_tgt
    tbl[0]  = mk(1, 64'h5,  5'b10000, 0, 0, 64'h0,   1,  1,  1, 64'h5,  4'b1000, 0, 64'h0);
    tbl[1]  = mk(1, 64'h6,  5'b10000, 0, 0, 64'h0,   1,  1,  1, 64'h6,  4'b1000, 0, 64'h0);
    tbl[2]  = mk(1, 64'h7,  5'b10000, 0, 0, 64'h0,   1,  1,  1, 64'h7,  4'b1000, 0, 64'h0);
    tbl[3]  = mk(0, 64'h0,  5'b00000, 0, 0, 64'h0,   1,  1,  0, 64'h7,  4'b1000, 0, 64'h0);
    tbl[4]  = mk(1, 64'h10, 5'b11100, 0, 0, 64'h0,   0,  1,  1, 64'h10, 4'b1110, 0, 64'h0);
    tbl[5]  = mk(1, 64'h20, 5'b00010, 0, 0, 64'h0,   0,  0,  1, 64'h10, 4'b1110, 0, 64'h0);
    tbl[6]  = mk(1, 64'h30, 5'b10000, 0, 0, 64'h0,   0,  0,  1, 64'h10, 4'b1110, 0, 64'h0);
    tbl[7]  = mk(1, 64'h30, 5'b10000, 0, 0, 64'h0,   1,  1,  1, 64'h20, 4'b0001, 0, 64'h0);
    tbl[8]  = mk(1, 64'h30, 5'b10000, 0, 0, 64'h0,   1,  1,  1, 64'h30, 4'b1000, 0, 64'h0);
    tbl[9]  = mk(0, 64'h0,  5'b00000, 0, 0, 64'h0,   1,  1,  0, 64'h30, 4'b1000, 0, 64'h0);
    tbl[10] = mk(1, 64'h40, 5'b00001, 1, 0, 64'h400, 0,  1,  1, 64'h40, 4'b0000, 1, 64'h400);
    tbl[11] = mk(0, 64'h0,  5'b00000, 0, 0, 64'h0,   0,  1,  1, 64'h40, 4'b0000, 0, 64'h400);
    tbl[12] = mk(1, 64'h50, 5'b00001, 0, 0, 64'h800, 0,  0,  1, 64'h40, 4'b0000, 0, 64'h400);
    tbl[13] = mk(0, 64'h0,  5'b00000, 0, 0, 64'h0,   1,  1,  1, 64'h50, 4'b0000, 0, 64'h400);
    tbl[14] = mk(1, 64'h60, 5'b10000, 0, 1, 64'hA00, 1,  1,  1, 64'h60, 4'b1000, 1, 64'hA00);
    tbl[15] = mk(0, 64'h0,  5'b00000, 0, 0, 64'h0,   1,  1,  0, 64'h60, 4'b1000, 0, 64'hA00);
    tbl[16] = mk(1, 64'h70, 5'b10000, 1, 0, 64'hB00, 1,  1,  1, 64'h70, 4'b1000, 0, 64'hA00);
    tbl[17] = mk(0, 64'h0,  5'b00000, 0, 0, 64'h0,   1,  1,  0, 64'h70, 4'b1000, 0, 64'hA00);

    // Reset state
    drive(0, 64'h0, 5'b00000, 0, 0, 64'h0, 0, 0);
    repeat (2) step();
    chk("reset ex_ready", u_if.ex_ready_o, 1);
    chk("reset mem_valid", u_if.mem_valid_o, 0);
    chk("reset br_taken", u_if.br_taken_o, 0);
    chk("reset alu", u_if.mem_alu_result_o, 0);
    chk("reset store", u_if.mem_store_data_o, 0);
    chk("reset rd", {59'd0, u_if.mem_rd_o}, 0);
    chk("reset ctrl", {60'd0, u_if.mem_ctrl_o}, 0);
    chk("reset br_target", u_if.br_target_o, 0);
    chk("reset perf_stall", {32'd0, u_if.perf_stall_o}, 0);
    chk("reset perf_br", {32'd0, u_if.perf_br_o}, 0);
    rst_n = 1'b1;

    // Streaming, back-pressure, branch resolution
    for (int i = 0; i < 18; i++) begin
      string tag;
      tag = $sformatf("row%0d", i);
      drive(tbl[i].v, tbl[i].alu, tbl[i].ctrl, tbl[i].zero, tbl[i].unc, tbl[i].tgt,
            tbl[i].mrdy, 0);
      step();
      chk({tag, " ex_ready"}, u_if.ex_ready_o, tbl[i].e_rdy);
      chk({tag, " mem_valid"}, u_if.mem_valid_o, tbl[i].e_mval);
      chk_data(tag, tbl[i].e_alu);
      chk({tag, " ctrl"}, {60'd0, u_if.mem_ctrl_o}, {60'd0, tbl[i].e_ctrl});
      chk({tag, " br_taken"}, u_if.br_taken_o, tbl[i].e_brt);
      chk({tag, " br_target"}, u_if.br_target_o, tbl[i].e_tgt);
    end

    // Flush with both entries full, then flush against a real handshake of a taken CBZ
    drive(1, 64'h100, 5'b10000, 0, 0, 64'h0, 0, 0);
    step();
    drive(1, 64'h200, 5'b10000, 0, 0, 64'h0, 0, 0);
    step();
    chk("full ex_ready", u_if.ex_ready_o, 0);
    chk("full mem_valid", u_if.mem_valid_o, 1);
    drive(1, 64'h300, 5'b00001, 1, 0, 64'hC00, 0, 1);
    step();
    chk("flush full mem_valid", u_if.mem_valid_o, 0);
    chk("flush full ex_ready", u_if.ex_ready_o, 1);
    chk("flush full br_taken", u_if.br_taken_o, 0);
    drive(0, 64'h0, 5'b00000, 0, 0, 64'h0, 1, 0);
    step();
    chk("post flush mem_valid", u_if.mem_valid_o, 0);
    drive(1, 64'h310, 5'b00001, 1, 0, 64'hD00, 1, 1);
    step();
    chk("flush hs mem_valid", u_if.mem_valid_o, 0);
    chk("flush hs br_taken", u_if.br_taken_o, 0);
    chk("flush hs br_target", u_if.br_target_o, 64'hA00);
    chk("flush hs ex_ready", u_if.ex_ready_o, 1);
    drive(0, 64'h0, 5'b00000, 0, 0, 64'h0, 1, 0);
    step();
    chk("dropped op mem_valid", u_if.mem_valid_o, 0);
    chk("dropped op br_taken", u_if.br_taken_o, 0);
    chk("flush holds alu", u_if.mem_alu_result_o, 64'h100);

    // Asynchronous reset with both entries valid and a branch pulse in flight
    drive(1, 64'h500, 5'b10000, 0, 0, 64'h0, 0, 0);
    step();
    drive(1, 64'h600, 5'b00001, 1, 0, 64'hE00, 0, 0);
    step();
    chk("pre reset br_taken", u_if.br_taken_o, 1);
    chk("pre reset ex_ready", u_if.ex_ready_o, 0);
    drive(0, 64'h0, 5'b00000, 0, 0, 64'h0, 0, 0);
    rst_n = 1'b0;
    #1;
    chk("async reset mem_valid", u_if.mem_valid_o, 0);
    chk("async reset ex_ready", u_if.ex_ready_o, 1);
    chk("async reset br_taken", u_if.br_taken_o, 0);
    chk("async reset alu", u_if.mem_alu_result_o, 0);
    chk("async reset br_target", u_if.br_target_o, 0);
    step();
    rst_n = 1'b1;
    drive(1, 64'h77, 5'b10000, 0, 0, 64'h0, 0, 0);
    step();
    chk("first accept mem_valid", u_if.mem_valid_o, 1);
    chk_data("first accept", 64'h77);

    // Perf counters: 7 stall cycles, 3 taken branches, one flushed branch that must not count
    rst_n = 1'b0;
    #1;
    chk("perf reset stall", {32'd0, u_if.perf_stall_o}, 0);
    chk("perf reset br", {32'd0, u_if.perf_br_o}, 0);
    step();
    rst_n = 1'b1;
    drive(1, 64'h900, 5'b10000, 0, 0, 64'h0, 0, 0);
    step();
    drive(0, 64'h0, 5'b00000, 0, 0, 64'h0, 0, 0);
    repeat (7) step();
    drive(0, 64'h0, 5'b00000, 0, 0, 64'h0, 1, 0);
    step();
    chk("perf drain mem_valid", u_if.mem_valid_o, 0);
    drive(1, 64'h910, 5'b00000, 0, 1, 64'h1100, 1, 0);
    step();
    drive(1, 64'h920, 5'b00001, 1, 0, 64'h1200, 1, 0);
    step();
    drive(1, 64'h930, 5'b00000, 0, 1, 64'h1300, 1, 0);
    step();
    chk("perf last br_target", u_if.br_target_o, 64'h1300);
    drive(1, 64'h940, 5'b00000, 0, 1, 64'h1400, 1, 1);
    step();
    drive(0, 64'h0, 5'b00000, 0, 0, 64'h0, 1, 0);
    step();
    chk("perf_stall", {32'd0, u_if.perf_stall_o}, {32'd0, EXP_STALL});
    chk("perf_br", {32'd0, u_if.perf_br_o}, {32'd0, EXP_BR});
    chk("perf end mem_valid", u_if.mem_valid_o, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
